tile_console_writer: RTL and testbench
======================================

Name: tile_console_writer

Overview:
- Text-console front end that fills the 80x30 tile-code RAM scanned by the tile-table/font-ROM pixel path.
- Accepts a byte stream of character codes on a valid/ready handshake and tracks a cursor.
- Handles newline, carriage return, backspace, form feed, line wrap and bottom-of-screen wrap.
- Emits single-port RAM write strobes, one tile code per cycle.

Parameters:
- COLS, 80, tiles per row.
- ROWS, 30, tile rows.
- ADDR_W, 12, tile-RAM address width (must hold COLS*ROWS-1 = 2399).
- BLANK, 8'h20, tile code written when clearing.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- char_data  in  8  incoming character code.
- char_valid  in  1  char_data valid.
- char_ready  out  1  writer can accept a character this cycle.
- wr_en  out  1  tile-RAM write strobe.
- wr_addr  out  ADDR_W  tile-RAM address, row*COLS+col.
- wr_data  out  8  tile code to write.
- cursor_x  out  7  current column, 0..COLS-1.
- cursor_y  out  5  current row, 0..ROWS-1.
- busy  out  1  a clear sequence is in progress.

Behaviour:
- Reset (async, Reset_n=0) forces the following, and does not clear RAM:
  - state=IDLE, cursor_x=0, cursor_y=0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - busy=0, char_ready=0 while asserted.
  - After release, char_ready=1 from the first clock edge.
- Reset mid-clear aborts the clear immediately; the remaining addresses are not written.
- States: IDLE, CLR_ROW, CLR_ALL.
- char_ready = (state==IDLE) && Reset_n, combinational from state.
- busy = (state!=IDLE).
- A transfer occurs on a rising edge with char_valid && char_ready. char_data is sampled only then.
- All write outputs are registered. The write for an accepted char appears in the cycle after the accept edge, for exactly 1 cycle.
- wr_en=0 in any cycle without a write.
- Printable char, 0x20..0x7E:
  - Write at the pre-advance cursor: wr_addr=cursor_y*COLS+cursor_x, wr_data=char.
  - Then cursor_x+1.
  - If cursor_x was COLS-1: cursor_x=0, cursor_y+1 (line wrap).
- 0x0A LF: cursor_x=0, cursor_y+1. No write.
- 0x0D CR: cursor_x=0. No write.
- 0x08 BS:
  - If cursor_x>0: cursor_x-1 and write BLANK at the new position.
  - If cursor_x==0: no action. No reverse line wrap.
- 0x0C FF:
  - Enter CLR_ALL and set cursor to 0,0 on the accept edge.
  - Write BLANK to addresses 0..COLS*ROWS-1, one per cycle, ascending: 2400 write cycles.
  - Return to IDLE on the edge after the last write is issued.
- Any other code is accepted and discarded. No write, no cursor change.
- Bottom wrap: any row increment from cursor_y==ROWS-1 (LF or line wrap) does the following:
  - Sets cursor_y=0, cursor_x=0.
  - Enters CLR_ROW, writing BLANK to addresses 0..COLS-1 (80 cycles), then returns to IDLE.
  - A printable char causing this is still written at its own address (row 29) first.
  - Its clear writes follow in consecutive cycles with no gap.
- Back-to-back accepts in IDLE are allowed every cycle: one write per cycle, no bubbles.
- Address arithmetic:
  - Computed at ADDR_W bits.
  - The clear counter is ADDR_W bits and stops exactly at its terminal count.
  - It never wraps past COLS*ROWS-1.
- char_valid during busy is ignored (char_ready=0). The source must hold char_valid and char_data until the accept.

Test Plan:
- Reset, then send 'A' (0x41), 'B' (0x42) on consecutive cycles -> writes addr 0 data 0x41, then addr 1 data 0x42 on consecutive cycles; cursor_x=2, cursor_y=0.
- Cursor at (79,3), send 0x41 -> write addr 319 data 0x41; cursor becomes (0,4); char_ready stays 1.
- Cursor at (5,29), send 0x0A -> cursor (0,0); busy=1 for 80 cycles; writes addr 0..79 data 0x20; char_ready=0 throughout, then 1.
- Cursor at (3,2), send 0x08 -> write addr 162 data 0x20, cursor (2,2). Then cursor at (0,2), send 0x08 -> no write, cursor unchanged.
- Send 0x0C with char_valid held high and next char 0x5A -> 2400 writes addr 0..2399 data 0x20; 0x5A is accepted only after busy drops and is written at addr 0.
- Assert Reset_n=0 mid-CLR_ALL (after addr 1000) -> wr_en drops immediately and cursor goes to (0,0); after release, char_ready=1 and no further clear writes occur.

Source files
------------

// File: rtl/tile_console_writer.sv
// tile_console_writer: text-console front end for the 80x30 tile-code RAM.
// Accepts character codes on a valid/ready handshake, tracks a cursor and
// emits one registered tile-RAM write per cycle. Handles LF, CR, BS, FF,
// line wrap and bottom-of-screen wrap (which blanks row 0).
//
// Ports:
//   Clk, Reset_n       clock, asynchronous active-low reset
//   char_data[7:0]     incoming character code
//   char_valid         char_data valid
//   char_ready         writer can accept a character (comb from state)
//   wr_en              tile-RAM write strobe
//   wr_addr[ADDR_W-1:0] tile-RAM address, row*COLS+col
//   wr_data[7:0]       tile code to write
//   cursor_x[6:0]      current column
//   cursor_y[4:0]      current row
//   busy               a clear sequence is in progress
module tile_console_writer #(
   parameter int unsigned COLS   = 80,
   parameter int unsigned ROWS   = 30,
   parameter int unsigned ADDR_W = 12,
   parameter logic [7:0]  BLANK  = 8'h20
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [7:0]        char_data,
   input  logic              char_valid,
   output logic              char_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [6:0]        cursor_x,
   output logic [4:0]        cursor_y,
   output logic              busy
);

   localparam logic [7:0] C_BS = 8'h08;
   localparam logic [7:0] C_LF = 8'h0A;
   localparam logic [7:0] C_FF = 8'h0C;
   localparam logic [7:0] C_CR = 8'h0D;

   localparam logic [6:0]        CX_LAST  = 7'(COLS - 1);
   localparam logic [4:0]        CY_LAST  = 5'(ROWS - 1);
   localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(COLS - 1);
   localparam logic [ADDR_W-1:0] ALL_LAST = ADDR_W'(COLS * ROWS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CLR_ROW = 2'd1,
      CLR_ALL = 2'd2
   } state_t;

   state_t            r_state,   w_state_nxt;
   logic [6:0]        r_cx,      w_cx_nxt;
   logic [4:0]        r_cy,      w_cy_nxt;
   logic [ADDR_W-1:0] r_cnt,     w_cnt_nxt;
   logic              r_wr_en,   w_wr_en_nxt;
   logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
   logic [7:0]        r_wr_data, w_wr_data_nxt;

   logic              w_ready;
   logic              w_accept;
   logic              w_row_inc;
   logic [ADDR_W-1:0] w_cur_addr;

   assign w_ready    = (r_state == IDLE);
   assign w_accept   = char_valid && w_ready;
   assign w_cur_addr = ADDR_W'(r_cy) * ADDR_W'(COLS) + ADDR_W'(r_cx);

   assign char_ready = w_ready && Reset_n;
   assign busy       = (r_state != IDLE);
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign cursor_x   = r_cx;
   assign cursor_y   = r_cy;

   // State and output registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= IDLE;
         r_cx      <= '0;
         r_cy      <= '0;
         r_cnt     <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cx      <= w_cx_nxt;
         r_cy      <= w_cy_nxt;
         r_cnt     <= w_cnt_nxt;
         r_wr_en   <= w_wr_en_nxt;
         r_wr_addr <= w_wr_addr_nxt;
         r_wr_data <= w_wr_data_nxt;
      end
   end

   // Next-state, cursor and write decode
   always_comb begin
      w_state_nxt   = r_state;
      w_cx_nxt      = r_cx;
      w_cy_nxt      = r_cy;
      w_cnt_nxt     = r_cnt;
      w_wr_en_nxt   = 1'b0;
      w_wr_addr_nxt = r_wr_addr;
      w_wr_data_nxt = r_wr_data;
      w_row_inc     = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                  w_wr_en_nxt   = 1'b1;
                  w_wr_addr_nxt = w_cur_addr;
                  w_wr_data_nxt = char_data;
                  if (r_cx == CX_LAST) w_row_inc = 1'b1;
                  else                 w_cx_nxt  = r_cx + 7'd1;
               end else begin
                  case (char_data)
                     C_LF: w_row_inc = 1'b1;
                     C_CR: w_cx_nxt  = '0;
                     C_BS: begin
                        // No reverse line wrap at column 0
                        if (r_cx != 7'd0) begin
                           w_cx_nxt      = r_cx - 7'd1;
                           w_wr_en_nxt   = 1'b1;
                           w_wr_addr_nxt = w_cur_addr - ADDR_W'(1);
                           w_wr_data_nxt = BLANK;
                        end
                     end
                     C_FF: begin
                        w_cx_nxt    = '0;
                        w_cy_nxt    = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = CLR_ALL;
                     end
                     default: ;
                  endcase
               end

               // Row advance; leaving the last row homes the cursor and blanks row 0
               if (w_row_inc) begin
                  w_cx_nxt = '0;
                  if (r_cy == CY_LAST) begin
                     w_cy_nxt    = '0;
                     w_cnt_nxt   = '0;
                     w_state_nxt = CLR_ROW;
                  end else begin
                     w_cy_nxt = r_cy + 5'd1;
                  end
               end
            end
         end

         CLR_ROW, CLR_ALL: begin
            // One blank per cycle; IDLE on the edge that issues the last write
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = r_cnt;
            w_wr_data_nxt = BLANK;
            if (r_cnt == ((r_state == CLR_ROW) ? ROW_LAST : ALL_LAST))
               w_state_nxt = IDLE;
            else
               w_cnt_nxt = r_cnt + ADDR_W'(1);
         end

         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_tile_console_writer.sv
// Directed bench for tile_console_writer: vector table for single-character
// behaviour plus hand-written sequences for wraps, clears and reset abort.
module tb_tile_console_writer;

   logic        Clk;
   logic        Reset_n;
   logic [7:0]  char_data;
   logic        char_valid;
   logic        char_ready;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic        busy;

   int checks = 0;
   int errors = 0;

   tile_console_writer dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .char_data  (char_data),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cursor_x   (cursor_x),
      .cursor_y   (cursor_y),
      .busy       (busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [7:0]  c;
      logic        wr;
      logic [11:0] addr;
      logic [7:0]  data;
      logic [6:0]  x;
      logic [4:0]  y;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Offer one char (called at a negedge), wait for accept; returns at the negedge after accept
   task automatic put(input logic [7:0] c);
      int w;
      w = 0;
      char_data  = c;
      char_valid = 1'b1;
      while (!char_ready && w < 5000) begin
         @(negedge Clk);
         w++;
      end
      if (!char_ready) chk("put_ready_timeout", 32'(char_ready), 32'd1);
      @(posedge Clk);
      #1 char_valid = 1'b0;
      @(negedge Clk);
   endtask

   task automatic step(input string name, input logic [7:0] c, input logic ewr,
                       input logic [11:0] eaddr, input logic [7:0] edata,
                       input logic [6:0] ex, input logic [4:0] ey);
      put(c);
      chk({name, "_wr_en"}, 32'(wr_en), 32'(ewr));
      if (ewr) begin
         chk({name, "_addr"}, 32'(wr_addr), 32'(eaddr));
         chk({name, "_data"}, 32'(wr_data), 32'(edata));
      end
      chk({name, "_x"}, 32'(cursor_x), 32'(ex));
      chk({name, "_y"}, 32'(cursor_y), 32'(ey));
   endtask

   task automatic put_n(input logic [7:0] c, input int n);
      for (int i = 0; i < n; i++) put(c);
   endtask

   // Starts at the negedge after the accept edge; expects an optional leading
   // char write, then n consecutive BLANK writes to 0..n-1 with busy high n cycles
   task automatic watch_clear(input string name, input int n, input logic lead,
                              input logic [11:0] laddr, input logic [7:0] ldata);
      int bad;
      int bcnt;
      int k;
      bad  = 0;
      bcnt = 0;
      for (k = 0; k < n + 10; k++) begin
         if (k > 0) @(negedge Clk);
         if (k == 0) begin
            if (lead) begin
               if (!(wr_en && wr_addr == laddr && wr_data == ldata)) bad++;
            end else if (wr_en) bad++;
         end else if (k <= n) begin
            if (!(wr_en && wr_addr == 12'(k - 1) && wr_data == 8'h20)) bad++;
         end else if (wr_en) bad++;
         if (busy) begin
            bcnt++;
            if (char_ready) bad++;
         end else break;
      end
      chk({name, "_bad_cycles"}, 32'(bad), 32'd0);
      chk({name, "_busy_cycles"}, 32'(bcnt), 32'(n));
      chk({name, "_ready_after"}, 32'(char_ready), 32'd1);
   endtask

   initial begin
      int w;
      int stray;

      tbl[0]  = '{8'h41, 1'b1, 12'd0,  8'h41, 7'd1, 5'd0};
      tbl[1]  = '{8'h42, 1'b1, 12'd1,  8'h42, 7'd2, 5'd0};
      tbl[2]  = '{8'h0D, 1'b0, 12'd0,  8'h00, 7'd0, 5'd0};
      tbl[3]  = '{8'h0A, 1'b0, 12'd0,  8'h00, 7'd0, 5'd1};
      tbl[4]  = '{8'h78, 1'b1, 12'd80, 8'h78, 7'd1, 5'd1};
      tbl[5]  = '{8'h08, 1'b1, 12'd80, 8'h20, 7'd0, 5'd1};
      tbl[6]  = '{8'h08, 1'b0, 12'd0,  8'h00, 7'd0, 5'd1};
      tbl[7]  = '{8'h01, 1'b0, 12'd0,  8'h00, 7'd0, 5'd1};
      tbl[8]  = '{8'h7F, 1'b0, 12'd0,  8'h00, 7'd0, 5'd1};
      tbl[9]  = '{8'h7E, 1'b1, 12'd80, 8'h7E, 7'd1, 5'd1};
      tbl[10] = '{8'h20, 1'b1, 12'd81, 8'h20, 7'd2, 5'd1};
      tbl[11] = '{8'h0A, 1'b0, 12'd0,  8'h00, 7'd0, 5'd2};

      Reset_n    = 1'b0;
      char_valid = 1'b0;
      char_data  = 8'h00;

      #12;
      chk("rst_wr_en",   32'(wr_en),      32'd0);
      chk("rst_wr_addr", 32'(wr_addr),    32'd0);
      chk("rst_wr_data", 32'(wr_data),    32'd0);
      chk("rst_x",       32'(cursor_x),   32'd0);
      chk("rst_y",       32'(cursor_y),   32'd0);
      chk("rst_busy",    32'(busy),       32'd0);
      chk("rst_ready",   32'(char_ready), 32'd0);

      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      chk("post_rst_ready", 32'(char_ready), 32'd1);

      // Back-to-back single-character vectors
      for (int i = 0; i < 12; i++)
         step($sformatf("vec%0d", i), tbl[i].c, tbl[i].wr, tbl[i].addr,
              tbl[i].data, tbl[i].x, tbl[i].y);

      // Line wrap at (79,3)
      put(8'h0A);
      put_n(8'h2E, 79);
      chk("lw_pre_x", 32'(cursor_x), 32'd79);
      step("line_wrap", 8'h41, 1'b1, 12'd319, 8'h41, 7'd0, 5'd4);
      chk("line_wrap_ready", 32'(char_ready), 32'd1);

      // LF from (5,29): bottom wrap clears row 0
      put_n(8'h0A, 25);
      put_n(8'h2E, 5);
      chk("bw_lf_pre_x", 32'(cursor_x), 32'd5);
      chk("bw_lf_pre_y", 32'(cursor_y), 32'd29);
      put(8'h0A);
      chk("bw_lf_x", 32'(cursor_x), 32'd0);
      chk("bw_lf_y", 32'(cursor_y), 32'd0);
      watch_clear("bw_lf", 80, 1'b0, 12'd0, 8'h00);

      // Printable at (79,29): own write first, then row-0 clear with no gap
      put_n(8'h0A, 29);
      put_n(8'h2E, 79);
      put(8'h51);
      chk("bw_chr_x", 32'(cursor_x), 32'd0);
      chk("bw_chr_y", 32'(cursor_y), 32'd0);
      watch_clear("bw_chr", 80, 1'b1, 12'd2399, 8'h51);

      // Backspace
      put_n(8'h0A, 2);
      put_n(8'h2E, 3);
      step("bs_col3", 8'h08, 1'b1, 12'd162, 8'h20, 7'd2, 5'd2);
      step("cr",      8'h0D, 1'b0, 12'd0,   8'h00, 7'd0, 5'd2);
      step("bs_col0", 8'h08, 1'b0, 12'd0,   8'h00, 7'd0, 5'd2);
      step("k",       8'h4B, 1'b1, 12'd160, 8'h4B, 7'd1, 5'd2);

      // Form feed with the next char held on the bus throughout the clear
      char_data  = 8'h0C;
      char_valid = 1'b1;
      @(posedge Clk);
      #1 char_data = 8'h5A;
      @(negedge Clk);
      chk("ff_x",     32'(cursor_x),   32'd0);
      chk("ff_y",     32'(cursor_y),   32'd0);
      chk("ff_busy",  32'(busy),       32'd1);
      chk("ff_ready", 32'(char_ready), 32'd0);
      watch_clear("ff", 2400, 1'b0, 12'd0, 8'h00);
      @(posedge Clk);
      #1 char_valid = 1'b0;
      @(negedge Clk);
      chk("ff_held_wr_en", 32'(wr_en),    32'd1);
      chk("ff_held_addr",  32'(wr_addr),  32'd0);
      chk("ff_held_data",  32'(wr_data),  32'h5A);
      chk("ff_held_x",     32'(cursor_x), 32'd1);
      chk("ff_held_y",     32'(cursor_y), 32'd0);

      // Reset in the middle of a full clear
      put(8'h0C);
      w = 0;
      while (!(wr_en && wr_addr == 12'd1000) && w < 1500) begin
         @(negedge Clk);
         w++;
      end
      chk("mid_clr_reached_1000", 32'(wr_en && wr_addr == 12'd1000), 32'd1);
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_wr_en", 32'(wr_en),      32'd0);
      chk("mid_rst_x",     32'(cursor_x),   32'd0);
      chk("mid_rst_y",     32'(cursor_y),   32'd0);
      chk("mid_rst_busy",  32'(busy),       32'd0);
      chk("mid_rst_ready", 32'(char_ready), 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge Clk);
         if (wr_en || busy || !char_ready) stray++;
      end
      chk("after_abort_quiet", 32'(stray),    32'd0);
      chk("after_abort_x",     32'(cursor_x), 32'd0);
      chk("after_abort_y",     32'(cursor_y), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
